mem_port_arbiter: RTL and testbench

//  Shares one physical memory port between the instruction-fetch requester (PC/IF) and the

---
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between instruction fetch and data requesters
// Optional ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed data-over-fetch priority.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              m_ce,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              stall_o,
    output logic              timeout_o
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t            state_q, state_d;
    logic              gnt_data_q, gnt_data_d;
    logic              m_ce_q, m_ce_d, m_we_q, m_we_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
    logic              timeout_q, timeout_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pick_data;
    logic [DATA_W-1:0] resp_data;

`ifdef ARB_ROUND_ROBIN_EN
    // Remembers whether the last grant went to data; reset value favours data on a tie.
    logic last_data_q, last_data_d;

    assign pick_data = d_req & (~if_req | ~last_data_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) last_data_q <= 1'b0;
        else      last_data_q <= last_data_d;
    end

    always_comb begin
        last_data_d = last_data_q;
        if (state_q == S_IDLE && (if_req || d_req)) last_data_d = pick_data;
    end
`else
    assign pick_data = d_req;
`endif

    assign resp_data = m_we_q ? '0 : m_rdata;

    always_comb begin
        state_d    = state_q;
        gnt_data_d = gnt_data_q;
        m_ce_d     = m_ce_q;
        m_we_d     = m_we_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;
        timeout_d  = timeout_q;
        cnt_d      = '0;
        case (state_q)
            S_IDLE: begin
                if (if_req || d_req) begin
                    gnt_data_d = pick_data;
                    m_ce_d     = 1'b1;
                    m_we_d     = pick_data ? d_we : 1'b0;
                    m_addr_d   = pick_data ? d_addr : if_addr;
                    m_wdata_d  = pick_data ? d_wdata : '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                // A ready response in the final counted cycle beats the abort.
                if (m_ready || cnt_q == CNT_MAX) begin
                    if (gnt_data_q) d_rdata_d  = m_ready ? resp_data : '0;
                    else            if_rdata_d = m_ready ? resp_data : '0;
                    if (!m_ready) timeout_d = 1'b1;
                    d_ack_d  = gnt_data_q;
                    if_ack_d = ~gnt_data_q;
                    m_ce_d   = 1'b0;
                    state_d  = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            gnt_data_q <= 1'b0;
            m_ce_q     <= 1'b0;
            m_we_q     <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
            timeout_q  <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            gnt_data_q <= gnt_data_d;
            m_ce_q     <= m_ce_d;
            m_we_q     <= m_we_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
            timeout_q  <= timeout_d;
            cnt_q      <= cnt_d;
        end
    end

    assign if_rdata  = if_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_rdata   = d_rdata_q;
    assign d_ack     = d_ack_q;
    assign m_ce      = m_ce_q;
    assign m_we      = m_we_q;
    assign m_addr    = m_addr_q;
    assign m_wdata   = m_wdata_q;
    assign timeout_o = timeout_q;
    assign stall_o   = (if_req & ~if_ack_q) | (d_req & ~d_ack_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (honours ARB_ROUND_ROBIN_EN)
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, m_ready = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0, m_rdata = '0;
    logic [DW-1:0] if_rdata, d_rdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic          if_ack, d_ack, m_ce, m_we, stall_o, timeout_o;

    int checks = 0;
    int failures = 0;
    bit last_d = 1'b0;
    bit exp_to = 1'b0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ready(m_ready),
        .stall_o(stall_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bound_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=expired expected=event", tag);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Tie rule: fixed priority gives data; round-robin gives whoever was not served last.
    function automatic bit model_pick_d(input bit fi, input bit fd);
`ifdef ARB_ROUND_ROBIN_EN
        if (fi && fd) return !last_d;
`endif
        return fd;
    endfunction

    // Plays the memory: waits for m_ce, answers on BUSY cycle lat (0 = never), returns what was seen.
    task automatic txn(input int lat, input logic [DW-1:0] rd,
                       output logic [AW-1:0] a, output logic w, output logic [DW-1:0] wd,
                       output logic ia, output logic da,
                       output logic [DW-1:0] ird, output logic [DW-1:0] drd, output int busy);
        int n;
        busy = 0; a = '0; w = 1'b0; wd = '0; ia = 1'b0; da = 1'b0; ird = '0; drd = '0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_ce && n < 8);
        if (!m_ce) begin
            bound_fail("grant_wait");
            return;
        end
        a = m_addr; w = m_we; wd = m_wdata;
        for (int b = 1; b <= TO + 4; b++) begin
            if (b == lat) begin
                m_ready = 1'b1;
                m_rdata = rd;
            end
            tick();
            m_ready = 1'b0;
            m_rdata = $urandom;
            if (if_ack || d_ack) begin
                busy = b;
                break;
            end
        end
        if (busy == 0) begin
            bound_fail("ack_wait");
            return;
        end
        ia = if_ack; da = d_ack; ird = if_rdata; drd = d_rdata;
        chk("resp_m_ce_low", m_ce, 1'b0);
    endtask

    task automatic serve(input string tag, input int lat, input logic [DW-1:0] rd);
        logic [AW-1:0] a, ea;
        logic [DW-1:0] wd, ird, drd, ewd, erd;
        logic          w, ia, da;
        int            busy;
        bit            pd, tmo, ew;
        pd  = model_pick_d(if_req, d_req);
        ea  = pd ? d_addr : if_addr;
        ew  = pd & d_we;
        ewd = pd ? d_wdata : '0;
        tmo = (lat == 0) || (lat > TO);
        erd = (tmo || ew) ? '0 : rd;
        txn(lat, rd, a, w, wd, ia, da, ird, drd, busy);
        last_d = pd;
        if (pd) d_req = 1'b0;
        else    if_req = 1'b0;
        if (busy == 0) return;
        exp_to = exp_to | tmo;
        chk({tag, "_m_addr"}, a, ea);
        chk({tag, "_m_we"}, w, ew);
        chk({tag, "_m_wdata"}, wd, ewd);
        chk({tag, "_acks"}, {ia, da}, {~pd, pd});
        chk({tag, "_rdata"}, pd ? drd : ird, erd);
        chk({tag, "_latency"}, busy, tmo ? TO : lat);
        chk({tag, "_timeout_o"}, timeout_o, exp_to);
        #1;
        chk({tag, "_stall_after_ack"}, stall_o, if_req | d_req);
        tick();
        chk({tag, "_acks_cleared"}, {if_ack, d_ack}, 2'b00);
    endtask

    initial begin
        tick();
        tick();
        chk("reset_m_ce", m_ce, 1'b0);
        chk("reset_m_we_addr_wdata", {m_we, m_addr, m_wdata}, '0);
        chk("reset_acks", {if_ack, d_ack}, 2'b00);
        chk("reset_rdata", {if_rdata, d_rdata}, '0);
        chk("reset_timeout_stall", {timeout_o, stall_o}, 2'b00);
        rst = 1'b1;
        tick();

        if_req = 1'b1; if_addr = 32'h0000_0010;
        #1;
        chk("t1_stall_pending", stall_o, 1'b1);
        serve("t1_fetch", 2, 32'h0000_0013);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0100; d_wdata = 32'hDEAD_BEEF;
        serve("t2_store", 1, 32'h1234_5678);

        for (int r = 0; r < 3; r++) begin
            if_req = 1'b1; if_addr = 32'h0000_0200 + r;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300 + r;
            serve("t3_first", 1, 32'hA000_0000 + r);
            chk("t3_other_still_stalls", stall_o, 1'b1);
            serve("t3_second", 3, 32'hB000_0000 + r);
        end

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0400;
        serve("t6_ready_on_last", TO, 32'hCAFE_0001);

        if_req = 1'b1; if_addr = 32'h0000_0500;
        serve("t4_abort", 0, 32'h5555_5555);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0600;
        serve("t4_after_abort", 2, 32'h7777_0001);

        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0700;
        tick();
        tick();
        chk("t5_busy_before_reset", m_ce, 1'b1);
        rst = 1'b0;
        #1;
        chk("t5_m_ce_drops", m_ce, 1'b0);
        chk("t5_no_ack", {if_ack, d_ack}, 2'b00);
        chk("t5_outputs_cleared", {m_addr, d_rdata, timeout_o}, '0);
        exp_to = 1'b0;
        last_d = 1'b0;
        tick();
        rst = 1'b1;
        serve("t5_reissue", 2, 32'h0BAD_F00D);

        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = $urandom_range(1, 3);
            if (mode[0]) begin
                if_req = 1'b1;
                if_addr = $urandom;
            end
            if (mode[1]) begin
                d_req = 1'b1;
                d_we = $urandom_range(0, 1);
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            #1;
            chk("rnd_stall_pending", stall_o, 1'b1);
            for (int k = 0; k < 2 && (if_req || d_req); k++)
                serve("rnd", $urandom_range(1, 6), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
